frame_capture: RTL and testbench

Parametrised single-frame capture engine between the VGA timing controller and the frame-buffer SRAM write port. After a power-up settle period, a rising edge on the capture request arms the block. It then writes exactly one complete frame from a programmable window to memory, in a selectable pixel format. The displayed frame is frozen until software releases the request.

---
 rtl/frame_capture.sv | 183 ++++++++++++++++++
 tb/tb_frame_capture.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// frame_capture: single-frame capture engine between the VGA timing
// controller and the frame-buffer SRAM write port. After a settle period a
// rising capture request arms the block; the next frame marker starts a
// one-frame windowed write to memory, and the display stays frozen until the
// request is released.
module frame_capture #(
  parameter int H_START       = 144,
  parameter int V_START       = 35,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int FRAME_X       = 143,
  parameter int FRAME_Y       = 34,
  parameter int SETTLE_FRAMES = 300,
  parameter int ADDR_W        = 20
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  input  logic [9:0]        iRed,
  input  logic [9:0]        iGreen,
  input  logic [9:0]        iBlue,
  input  logic [12:0]       iX,
  input  logic [12:0]       iY,
  input  logic              iStart,
  input  logic [1:0]        iMode,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [15:0]       oMemData,
  output logic              oMemWE,
  output logic              oStopCapture,
  output logic              oReady,
  output logic              oLed,
  output logic              oBusy
);

  typedef enum logic [2:0] {SETTLE, IDLE, ARMED, CAPTURE, DONE} state_t;

  localparam logic [12:0] MK_X     = 13'(FRAME_X);
  localparam logic [12:0] MK_Y     = 13'(FRAME_Y);
  localparam logic [12:0] X_LO     = 13'(H_START);
  localparam logic [12:0] X_HI     = 13'(H_START + H_RES);
  localparam logic [12:0] Y_LO     = 13'(V_START);
  localparam logic [12:0] Y_HI     = 13'(V_START + V_RES);
  localparam logic [15:0] SETTLE_N = 16'(SETTLE_FRAMES);
  // Wide enough for a full 13-bit line offset times the line width.
  localparam int          CALC_W   = ADDR_W + 14;

  state_t              state, state_nxt;
  logic                mk_hit, mk_prev, mk;
  logic                start_prev, start_rise;
  logic [15:0]         frame_cnt;
  logic                settle_done;
  logic [1:0]          mode_q;
  logic                in_window, we;
  logic [CALC_W-1:0]   x_off, y_off, lin_addr;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                unused_bits;

  // Map one pixel into the selected 16-bit memory word.
  function automatic logic [15:0] fmt_pixel(input logic [1:0] m,
                                            input logic [9:0] r,
                                            input logic [7:0] g8,
                                            input logic [7:0] b8);
    logic [9:0] grey_sum;
    grey_sum = {2'b00, r[9:2]} + {1'b0, g8, 1'b0} + {2'b00, b8};
    case (m)
      2'b00:   return {6'b0, r};
      2'b01:   return {r[9:5], g8[7:2], b8[7:3]};
      2'b10:   return {8'b0, grey_sum[9:2]};
      default: return {8'b0, g8};
    endcase
  endfunction

  // A marker held for several cycles yields a single one-cycle mk.
  assign mk_hit     = (iX == MK_X) && (iY == MK_Y);
  assign mk         = mk_hit && !mk_prev;
  assign start_rise = iStart && !start_prev;

  assign settle_done = (frame_cnt >= SETTLE_N) ||
                       (mk && ((frame_cnt + 16'd1) >= SETTLE_N));

  assign in_window = (iX >= X_LO) && (iX < X_HI) && (iY >= Y_LO) && (iY < Y_HI);
  assign x_off     = CALC_W'(iX) - CALC_W'(X_LO);
  assign y_off     = CALC_W'(iY) - CALC_W'(Y_LO);
  assign lin_addr  = y_off * CALC_W'(H_RES) + x_off;
  assign addr_nxt  = lin_addr[ADDR_W-1:0];

  assign unused_bits = ^{iGreen[1:0], iBlue[1:0], lin_addr[CALC_W-1:ADDR_W]};

  // Edge-detect registers for the marker and the capture request.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      mk_prev    <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      mk_prev    <= mk_hit;
      start_prev <= iStart;
    end
  end

  // Settle frame counter, saturating at the settle target.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      frame_cnt <= 16'd0;
    else if (state == SETTLE && mk && frame_cnt < SETTLE_N)
      frame_cnt <= frame_cnt + 16'd1;
  end

  // Pixel format is frozen at the arming edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      mode_q <= 2'b00;
    else if (state == IDLE && start_rise)
      mode_q <= iMode;
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)
      state <= SETTLE;
    else
      state <= state_nxt;
  end

  // Next-state, write strobe and status outputs; a falling request always
  // takes priority over a marker.
  always_comb begin
    state_nxt    = state;
    we           = 1'b0;
    oStopCapture = 1'b0;
    oReady       = 1'b0;
    oLed         = 1'b1;
    oBusy        = 1'b0;
    case (state)
      SETTLE: begin
        oLed = 1'b0;
        if (settle_done) state_nxt = IDLE;
      end
      IDLE: begin
        if (start_rise) state_nxt = ARMED;
      end
      ARMED: begin
        oBusy = 1'b1;
        if (!iStart) begin
          state_nxt = IDLE;
        end else if (mk) begin
          state_nxt = CAPTURE;
          we        = in_window;
        end
      end
      CAPTURE: begin
        oBusy        = 1'b1;
        oStopCapture = 1'b1;
        if (!iStart)  state_nxt = IDLE;
        else if (mk)  state_nxt = DONE;
        else          we = in_window;
      end
      DONE: begin
        oStopCapture = 1'b1;
        oReady       = 1'b1;
        if (!iStart) state_nxt = IDLE;
      end
      default: begin
        oLed      = 1'b0;
        state_nxt = SETTLE;
      end
    endcase
  end

  // Registered write port; address and data hold while no write is issued.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oMemWE   <= 1'b0;
      oMemAddr <= '0;
      oMemData <= 16'd0;
    end else begin
      oMemWE <= we;
      if (we) begin
        oMemAddr <= addr_nxt;
        oMemData <= fmt_pixel(mode_q, iRed, iGreen[9:2], iBlue[9:2]);
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Directed testbench for frame_capture using a small 8x4 window.
module tb_frame_capture;

  localparam int HS = 4;
  localparam int VS = 2;
  localparam int HR = 8;
  localparam int VR = 4;
  localparam int FX = 1;
  localparam int FY = 0;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [9:0]    red = '0, green = '0, blue = '0;
  logic [12:0]   x = '0, y = '0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;

  logic [AW-1:0] mem_addr, mem_addr2;
  logic [15:0]   mem_data, mem_data2;
  logic          mem_we, stop_cap, ready, led, busy;
  logic          mem_we2, stop_cap2, ready2, led2, busy2;

  int tests_run = 0;
  int tests_failed = 0;

  logic [AW-1:0] wr_addr[$];
  logic [15:0]   wr_data[$];

  always #5 clk = ~clk;

  frame_capture #(
    .H_START(HS), .V_START(VS), .H_RES(HR), .V_RES(VR),
    .FRAME_X(FX), .FRAME_Y(FY), .SETTLE_FRAMES(3), .ADDR_W(AW)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .iX(x), .iY(y), .iStart(start), .iMode(mode),
    .oMemAddr(mem_addr), .oMemData(mem_data), .oMemWE(mem_we),
    .oStopCapture(stop_cap), .oReady(ready), .oLed(led), .oBusy(busy)
  );

  frame_capture #(
    .H_START(HS), .V_START(VS), .H_RES(HR), .V_RES(VR),
    .FRAME_X(FX), .FRAME_Y(FY), .SETTLE_FRAMES(2), .ADDR_W(AW)
  ) dut2 (
    .iCLK(clk), .iRST_N(rst_n), .iRed(red), .iGreen(green), .iBlue(blue),
    .iX(x), .iY(y), .iStart(start), .iMode(mode),
    .oMemAddr(mem_addr2), .oMemData(mem_data2), .oMemWE(mem_we2),
    .oStopCapture(stop_cap2), .oReady(ready2), .oLed(led2), .oBusy(busy2)
  );

  // Record every write issued by the main instance.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_data);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic do_reset(input logic start_lvl);
    rst_n = 1'b0;
    start = start_lvl;
    mode  = 2'b00;
    x = '0; y = '0; red = '0; green = '0; blue = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic pulse_marker();
    @(negedge clk);
    x = 13'(FX); y = 13'(FY);
    @(negedge clk);
    x = '0; y = '0;
  endtask

  task automatic arm_and_capture(input logic [1:0] m);
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    pulse_marker();
  endtask

  // Scan the window rows plus one pixel either side of each row.
  task automatic scan_frame(input logic use_index, input logic [9:0] r,
                            input logic [9:0] g, input logic [9:0] b,
                            input int abort_n);
    int n;
    n = 0;
    for (int yy = VS; yy < VS + VR; yy++) begin
      for (int xx = HS - 1; xx <= HS + HR; xx++) begin
        @(negedge clk);
        x = 13'(xx); y = 13'(yy);
        if (xx >= HS && xx < HS + HR) begin
          red   = use_index ? 10'(n) : r;
          green = g;
          blue  = b;
          if (n == abort_n) start = 1'b0;
          n++;
        end
      end
    end
    @(negedge clk);
    x = '0; y = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({mem_we, stop_cap, ready, led, busy} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_status: got %b required 00000", {mem_we, stop_cap, ready, led, busy});
    end
    tests_run++;
    if ({mem_addr, mem_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mem: got addr %h data %h required 0", mem_addr, mem_data);
    end
  endtask

  task automatic test_settle();
    do_reset(1'b1);
    pulse_marker();
    pulse_marker();
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_led_early: got %b required 0", led);
    end
    pulse_marker();
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL settle_led_rise: got %b required 1", led);
    end
    pulse_marker();
    scan_frame(1'b1, '0, '0, '0, -1);
    tests_run++;
    if (wr_addr.size() !== 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_held_start: got writes %0d busy %b required 0 0", wr_addr.size(), busy);
    end
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL settle_rearm: got busy %b required 1", busy);
    end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL settle_release: got busy %b required 0", busy);
    end
  endtask

  task automatic test_full_frame();
    int bad;
    wr_addr.delete(); wr_data.delete();
    @(negedge clk);
    mode = 2'b00; start = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({busy, stop_cap, ready} !== 3'b100) begin
      tests_failed++;
      $display("FAIL armed_status: got busy/stop/ready %b required 100", {busy, stop_cap, ready});
    end
    pulse_marker();
    tests_run++;
    if ({busy, stop_cap, ready} !== 3'b110) begin
      tests_failed++;
      $display("FAIL capture_status: got busy/stop/ready %b required 110", {busy, stop_cap, ready});
    end
    scan_frame(1'b1, '0, '0, '0, -1);
    pulse_marker();
    tests_run++;
    if (wr_addr.size() !== 32) begin
      tests_failed++;
      $display("FAIL frame_count: got %0d writes required 32", wr_addr.size());
    end
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 32; i++)
      if (wr_addr[i] !== AW'(i) || wr_data[i] !== 16'(i)) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL frame_addr_data: got %0d wrong writes required 0", bad);
    end
    tests_run++;
    if ({busy, stop_cap, ready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL done_status: got busy/stop/ready %b required 011", {busy, stop_cap, ready});
    end
    pulse_marker();
    tests_run++;
    if (ready !== 1'b1 || wr_addr.size() !== 32) begin
      tests_failed++;
      $display("FAIL done_hold: got ready %b writes %0d required 1 32", ready, wr_addr.size());
    end
    start = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({led, busy, stop_cap, ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL done_release: got led/busy/stop/ready %b required 1000", {led, busy, stop_cap, ready});
    end
  endtask

  task automatic test_formats();
    logic [1:0]  t_mode[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [9:0]  t_r[4]    = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h000};
    logic [9:0]  t_g[4]    = '{10'h000, 10'h000, 10'h000, 10'h3FC};
    logic [15:0] t_exp[4]  = '{16'h03FF, 16'hF800, 16'h003F, 16'h00FF};
    for (int k = 0; k < 4; k++) begin
      wr_addr.delete(); wr_data.delete();
      arm_and_capture(t_mode[k]);
      scan_frame(1'b0, t_r[k], t_g[k], 10'h000, -1);
      tests_run++;
      if (wr_data.size() !== 32 || wr_data[0] !== t_exp[k] || wr_data[31] !== t_exp[k]) begin
        tests_failed++;
        $display("FAIL format_mode%0d: got %0d writes first %h last %h required 32 x %h",
                 k, wr_data.size(), wr_data[0], wr_data[31], t_exp[k]);
      end
      pulse_marker();
      start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    wr_addr.delete(); wr_data.delete();
    arm_and_capture(2'b00);
    scan_frame(1'b1, '0, '0, '0, 10);
    tests_run++;
    if (wr_addr.size() !== 10 || wr_addr[9] !== AW'(9)) begin
      tests_failed++;
      $display("FAIL abort_writes: got %0d writes required 10 ending at 9", wr_addr.size());
    end
    tests_run++;
    if ({led, busy, stop_cap, ready} !== 4'b1000) begin
      tests_failed++;
      $display("FAIL abort_status: got led/busy/stop/ready %b required 1000", {led, busy, stop_cap, ready});
    end
    pulse_marker();
    tests_run++;
    if (ready !== 1'b0 || wr_addr.size() !== 10) begin
      tests_failed++;
      $display("FAIL abort_no_ready: got ready %b writes %0d required 0 10", ready, wr_addr.size());
    end
  endtask

  task automatic test_reset_mid();
    arm_and_capture(2'b01);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      x = 13'(HS + k); y = 13'(VS);
      red = 10'h3FF;
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({mem_we, stop_cap, ready, led, busy} !== 5'b0 || {mem_addr, mem_data} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got we/stop/ready/led/busy %b addr %h data %h required 0",
               {mem_we, stop_cap, ready, led, busy}, mem_addr, mem_data);
    end
    @(negedge clk);
    x = '0; y = '0; start = 1'b0; red = '0;
    rst_n = 1'b1;
    pulse_marker();
    pulse_marker();
    tests_run++;
    if (led !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_resettle: got led %b required 0", led);
    end
    pulse_marker();
    tests_run++;
    if (led !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_settle_done: got led %b required 1", led);
    end
  endtask

  task automatic test_marker_hold();
    do_reset(1'b0);
    @(negedge clk);
    x = 13'(FX); y = 13'(FY);
    repeat (5) @(negedge clk);
    x = '0; y = '0;
    @(negedge clk);
    tests_run++;
    if (led2 !== 1'b0) begin
      tests_failed++;
      $display("FAIL marker_hold_once: got led %b required 0", led2);
    end
    x = 13'(FX); y = 13'(FY);
    repeat (5) @(negedge clk);
    x = '0; y = '0;
    tests_run++;
    if (led2 !== 1'b1) begin
      tests_failed++;
      $display("FAIL marker_hold_second: got led %b required 1", led2);
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_full_frame();
    test_formats();
    test_abort();
    test_reset_mid();
    test_marker_hold();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
